mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Read-back engine on the far side of the Microprocessor program-load interface.
- Waits for program_done_flag, then walks the processor's select_mem/output_mem_cell debug port over a programmed address window.
- Streams each captured 24-bit word out on a valid/ready interface to the result consumer (display, UART formatter, or bench scoreboard).

Parameters:
- DATA_W, 24, width of a memory cell and of out_data.
- ADDR_W, 7, width of select_mem and of the address space (128 cells).
- SETTLE_CYC, 1, cycles select_mem is held before mem_data is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle request to arm a dump; ignored while busy=1.
- base_addr  in  ADDR_W  first cell address; sampled on an accepted start.
- length  in  8  number of cells to read, 0..128; sampled on an accepted start.
- done_flag  in  1  the Microprocessor program_done_flag.
- select_mem  out  ADDR_W  drives the Microprocessor select_mem.
- mem_data  in  DATA_W  the Microprocessor output_mem_cell.
- out_valid  out  1  out_data and out_addr hold a captured word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured cell contents.
- out_addr  out  ADDR_W  address the word was read from.
- busy  out  1  high from an accepted start until dump_done.
- dump_done  out  1  one-cycle pulse when the window is complete.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. select_mem=0, out_valid=0, out_data=0, out_addr=0, busy=0, dump_done=0. Reset mid-dump abandons the transfer; no partial dump_done.
- IDLE: start=1 latches base_addr into cur_addr and length into remaining; busy<=1; next state WAIT_DONE.
- WAIT_DONE: done_flag is sampled each edge.
  - On the edge where done_flag=1 and remaining=0: go to FINISH.
  - On the edge where done_flag=1 and remaining>0: select_mem<=cur_addr, settle counter<=SETTLE_CYC, next state SETTLE.
  - If done_flag is already high when start is accepted, it is seen on the following edge.
- SETTLE: the counter decrements each edge. On the edge where it equals 1: out_data<=mem_data, out_addr<=select_mem, out_valid<=1, next state PRESENT.
  - out_valid therefore rises SETTLE_CYC edges after select_mem changes.
- PRESENT: out_valid, out_data and out_addr are held stable until out_ready=1.
  - On the handshake edge with remaining=1: out_valid<=0, remaining<=0, next state FINISH.
  - On the handshake edge otherwise: out_valid<=0, remaining decrements, cur_addr and select_mem <= cur_addr+1, then return to SETTLE with the counter reloaded.
  - Address increment wraps modulo 2^ADDR_W (127 -> 0).
- FINISH: dump_done=1 for exactly one cycle, busy<=0, next state IDLE. select_mem keeps its last value.
- Throughput with out_ready tied high: one word per SETTLE_CYC+1 cycles.
- done_flag is only examined in WAIT_DONE. Deassertion during SETTLE or PRESENT is ignored.
- start during busy is dropped and not queued. A start in the same cycle as the dump_done pulse is also ignored; it is accepted only in IDLE.
- length>128 is not supported. Values 129..255 are truncated to 128 reads.

Decomposition:
- Shared package (alongside the processor's instruction definitions) holds:
  - DATA_W and ADDR_W constants, shared with the Microprocessor instruction/memory widths.
  - The state enum IDLE, WAIT_DONE, SETTLE, PRESENT, FINISH.
- One sub-module is natural: dump_addr_counter, holding cur_addr, remaining, wrap and last-word detection. The FSM and output register stay in the top module.

Test Plan:
- Memory model returns mem_data = 3*select_mem+5. Inputs: base_addr=40, length=3, SETTLE_CYC=1, out_ready=1, done_flag raised 10 cycles after start. Expect words (40,125), (41,128), (42,131) on consecutive handshakes 2 cycles apart, dump_done one cycle after the last handshake, then busy=0.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1. Expect out_data, out_addr and select_mem unchanged throughout, and exactly one transfer when out_ready rises.
- Wrap: base_addr=126, length=4. Expect out_addr sequence 126, 127, 0, 1 and data 383, 386, 5, 8.
- Zero length: length=0 with done_flag=1. Expect no out_valid, and dump_done one cycle after the WAIT_DONE edge.
- Asynchronous reset: drop reset to 0 while in PRESENT after word 2 of 5. Expect out_valid, busy and select_mem to go to 0 immediately, no dump_done, and a fresh start afterwards to work from base_addr.
- Ignored start: pulse start with base_addr=0 during an active dump. Expect the active window to complete unchanged and no second dump to occur.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// Widths and state encoding shared between the program-load interface and the
// memory read-back engine.
package mem_dump_reader_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 7;
  localparam int LEN_W  = 8;

  // Largest window the address space can hold; longer requests are clipped.
  localparam logic [LEN_W-1:0] MAX_LEN = 8'd128;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    SETTLE,
    PRESENT,
    FINISH
  } state_t;

endpackage

// File: rtl/mem_dump_reader_addr_counter.sv
// Walks the dump window: current cell address, cells still to read, and
// wrap / last-word detection for the sequencing FSM.
module dump_addr_counter
  import mem_dump_reader_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] length,
  output logic [AW-1:0]    cur_addr,
  output logic [AW-1:0]    next_addr,
  output logic             is_last,
  output logic             is_empty
);

  logic [LEN_W-1:0] remaining;

  // Natural AW-bit overflow gives the 127 -> 0 wrap.
  assign next_addr = cur_addr + AW'(1);
  assign is_last   = (remaining == LEN_W'(1));
  assign is_empty  = (remaining == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= base_addr;
      remaining <= (length > MAX_LEN) ? MAX_LEN : length;
    end else if (advance) begin
      cur_addr  <= next_addr;
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Read-back engine: after program load completes, steps select_mem over a
// window and streams each captured cell out on a valid/ready port.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_DONE | armed, waiting for the processor's program_done_flag
// SETTLE    | select_mem driven, waiting SETTLE_CYC edges before sampling
// PRESENT   | captured word offered on out_*, waiting for out_ready
// FINISH    | one-cycle dump_done pulse
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int DATA_W     = mem_dump_reader_pkg::DATA_W,
  parameter int ADDR_W     = mem_dump_reader_pkg::ADDR_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        length,
  input  logic              done_flag,
  output logic [ADDR_W-1:0] select_mem,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              dump_done
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t            state, state_nxt;
  logic [3:0]        settle_cnt;
  logic              load, advance, is_last, is_empty;
  logic [ADDR_W-1:0] cur_addr, next_addr;

  dump_addr_counter #(.AW(ADDR_W)) u_addr_counter (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load),
    .advance   (advance),
    .base_addr (base_addr),
    .length    (length),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .is_last   (is_last),
    .is_empty  (is_empty)
  );

  assign busy      = (state != IDLE);
  assign dump_done = (state == FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_flag) state_nxt = is_empty ? FINISH : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd1) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          advance   = 1'b1;
          state_nxt = is_last ? FINISH : SETTLE;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output word and select_mem only move on the edges named below, so they
  // stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      select_mem <= '0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
    end else begin
      case (state)
        WAIT_DONE: begin
          if (done_flag && !is_empty) begin
            select_mem <= cur_addr;
            settle_cnt <= SETTLE_LD;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd1) begin
            out_data  <= mem_data;
            out_addr  <= select_mem;
            out_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!is_last) begin
              select_mem <= next_addr;
              settle_cnt <= SETTLE_LD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: expected words are queued at start
// time from a plain window model, and a negedge monitor checks each handshake.
module tb_mem_dump_reader;

  localparam int AW = 7;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          done_flag = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    length = '0;
  logic [AW-1:0] select_mem, out_addr;
  logic [DW-1:0] mem_data, out_data;
  logic          out_valid, busy, dump_done;

  logic [DW-1:0] mem [128];

  mem_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SETTLE_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .done_flag  (done_flag),
    .select_mem (select_mem),
    .mem_data   (mem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;
  assign mem_data = mem[select_mem];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  word_t exp_q[$];
  int    hs_cyc[$];
  int    total = 0, bad = 0;
  int    cyc = 0, done_cnt = 0, hs_cnt = 0, valid_cnt = 0, last_done_cyc = 0;
  bit    rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rand_ready) #1 out_ready = 1'($urandom % 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake the DUT will take.
  always @(negedge clk) begin
    if (reset) begin
      if (dump_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual_addr=%0d actual_data=%0d required=none", out_addr, out_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("out_addr", 32'(out_addr), 32'(e.a));
          check("out_data", 32'(out_data), 32'(e.d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference window: min(len,128) consecutive cells from base, modulo 128.
  task automatic start_dump(input int base, input int len);
    int    n;
    word_t w;
    n = (len > 128) ? 128 : len;
    for (int i = 0; i < n; i++) begin
      w.a = AW'((base + i) % 128);
      w.d = mem[(base + i) % 128];
      exp_q.push_back(w);
    end
    base_addr = AW'(base);
    length    = 8'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_dump_done(input string name, input int bound);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    tick();
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n;
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, d0, v0, h0;
    for (int i = 0; i < 128; i++) mem[i] = DW'(3 * i + 5);

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_select_mem", 32'(select_mem), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();

    // Basic window, done_flag raised 10 cycles after start
    out_ready = 1'b1;
    hs_cyc.delete();
    start_dump(40, 3);
    repeat (9) tick();
    check("basic_busy_waiting", 32'(busy), 32'd1);
    check("basic_no_early_word", 32'(hs_cnt), 32'd0);
    done_flag = 1'b1;
    wait_dump_done("basic", 50);
    check("basic_words", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("basic_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      check("basic_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
      check("basic_done_latency", 32'(last_done_cyc - hs_cyc[2]), 32'd1);
    end
    done_flag = 1'b0;

    // Backpressure: five stalled cycles with out_valid high
    out_ready = 1'b0;
    done_flag = 1'b1;
    start_dump(10, 2);
    wait_valid("bp", 20);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_addr_held", 32'(out_addr), 32'd10);
      check("bp_data_held", 32'(out_data), 32'(mem[10]));
      check("bp_select_held", 32'(select_mem), 32'd10);
      tick();
    end
    h0 = hs_cnt;
    out_ready = 1'b1;
    tick();
    check("bp_one_transfer", 32'(hs_cnt - h0), 32'd1);
    check("bp_valid_drops", 32'(out_valid), 32'd0);
    wait_dump_done("bp", 50);

    // Address wrap 126,127,0,1
    start_dump(126, 4);
    wait_dump_done("wrap", 50);

    // Zero length with done_flag already high
    v0 = valid_cnt;
    s  = cyc;
    start_dump(0, 0);
    wait_dump_done("zero", 20);
    check("zero_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("zero_done_timing", 32'(last_done_cyc - s), 32'd2);

    // Async reset while word 3 of 5 is presented
    out_ready = 1'b0;
    start_dump(20, 5);
    for (int k = 0; k < 2; k++) begin
      wait_valid("rstmid_hs", 20);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_valid("rstmid_word3", 20);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_select_mem", 32'(select_mem), 32'd0);
    check("rstmid_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    out_ready = 1'b1;
    start_dump(20, 2);
    wait_dump_done("rstmid_fresh", 50);

    // start during an active dump is dropped
    start_dump(50, 3);
    tick();
    base_addr = '0;
    length    = 8'd5;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_dump_done("ignstart", 50);
    d0 = done_cnt;
    v0 = valid_cnt;
    repeat (20) tick();
    check("ignstart_no_second_dump", 32'(done_cnt - d0), 32'd0);
    check("ignstart_no_extra_valid", 32'(valid_cnt - v0), 32'd0);

    // Randomized windows, memory contents and consumer stalls
    for (int r = 0; r < 8; r++) begin
      int base, len, dly;
      for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
      base = int'($urandom_range(0, 127));
      len  = int'($urandom_range(0, 140));
      dly  = int'($urandom_range(0, 5));
      done_flag  = 1'b0;
      rand_ready = 1'b1;
      start_dump(base, len);
      repeat (dly) tick();
      done_flag = 1'b1;
      wait_dump_done("rand", 3000);
      rand_ready = 1'b0;
      #1 out_ready = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
